pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with valid/ready handshake, two-entry skid buffer and synchronous flush. Generalises the fixed 32+32-bit, flush-only stage register into a single block usable between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Back-pressure from the downstream stage stalls the upstream stage without combinational ready paths. Flush inserts a bubble carrying a configurable NOP payload.

## Interface
- DATA_W, 64, payload width in bits (IF/ID use: {pc, instr}).
- FLUSH_VAL, {DATA_W{1'b0}}, payload driven on out_data_o after reset or flush (all-zero = NOP).
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- flush_i  input  1  discard all held entries; synchronous.
- in_valid_i  input  1  upstream presents a payload.
- in_ready_o  output  1  stage can accept; driven directly from a flop.
- in_data_i  input  DATA_W  upstream payload.
- out_valid_o  output  1  payload on out_data_o is valid.
- out_ready_i  input  1  downstream accepts.
- out_data_o  output  DATA_W  payload to downstream.
- occ_o  output  2  entries held (0..2).

## Operation
- in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Storage: main register (drives out_data_o) and skid register.
- States: EMPTY (occ 0), FULL (main valid), SKID (main and skid valid).
- EMPTY: in_fire -> FULL, main <= in_data_i.
- FULL: in_fire & out_fire -> FULL, main <= in_data_i; in_fire & !out_fire -> SKID, skid <= in_data_i; !in_fire & out_fire -> EMPTY; else hold.
- SKID: no in_fire possible; out_fire -> FULL, main <= skid; else hold.
- in_ready_o = (state != SKID); out_valid_o = (state != EMPTY).
- Priority: rst_i > flush_i > handshake.
- flush_i: next state EMPTY, main <= FLUSH_VAL, skid contents don't-care. A payload offered in the flush cycle is dropped, even if in_fire is high. An out_fire in that cycle still counts as delivered.
- While out_valid_o & !out_ready_i, out_data_o must not change.
- In EMPTY, out_data_o holds its last loaded value (FLUSH_VAL after reset or flush). Downstream must qualify on out_valid_o.
- No payload is ever duplicated, reordered or lost, except on flush.

## Timing
- Reset values: out_valid_o 0, in_ready_o 1, occ_o 0, out_data_o FLUSH_VAL.
- Latency: payload accepted in cycle N appears on out_data_o in cycle N+1.
- Throughput: 1 payload per cycle while out_ready_i is high.
- in_ready_o falls the cycle after the stall-causing accept, not the same cycle. The skid entry absorbs that payload.
- No combinational path from out_ready_i to in_ready_o, or from in_data_i to out_data_o.
- Flush takes effect next edge: cycle after flush has out_valid_o 0, in_ready_o 1, occ_o 0.
- Reset asserted mid-transfer behaves as flush but also forces FLUSH_VAL on out_data_o; held payloads are lost.

## Structure
- Shared package pipe_pkg: state typedef (EMPTY=2'd0, FULL=2'd1, SKID=2'd2), default NOP constants per stage (e.g. IF_ID_NOP).
- Single module; no sub-module needed.
- Thin stage wrappers (e.g. if_id_stage: DATA_W=64, pc/instr split) instantiate it.

## Test plan
- Reset: hold rst_i 2 cycles with in_valid_i=1 -> out_valid_o 0, in_ready_o 1, occ_o 0, out_data_o=FLUSH_VAL. No accept occurs.
- Streaming: out_ready_i=1, send 0x1..0x8 back-to-back -> each appears one cycle later, in order. in_ready_o stays 1 and occ_o stays 1.
- Back-pressure: out_ready_i=0, send 0xA, 0xB, 0xC -> 0xA in main, 0xB in skid, in_ready_o 0, occ_o 2, 0xC not accepted. Raise out_ready_i -> 0xA, 0xB, 0xC delivered in order, none lost.
- Flush in SKID, with in_valid_i=1 data 0xD in the same cycle -> next cycle occ_o 0, out_valid_o 0, out_data_o=FLUSH_VAL. 0xD is never delivered.
- Flush with out_fire in the same cycle -> the held payload counts as delivered once, then EMPTY.
- Random valid/ready over 10k cycles, scoreboard check -> in-order, no loss or duplication; out_data_o stable while stalled.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: handshake state encoding,
// per-stage bubble payloads and an occupancy helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

  // Bubble payloads; IF/ID carries {pc, instr} with instr = addi x0,x0,0.
  localparam logic [63:0] IF_ID_NOP  = {32'h0000_0000, 32'h0000_0013};
  localparam logic [63:0] ID_EX_NOP  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] EX_MEM_NOP = 64'h0000_0000_0000_0000;
  localparam logic [63:0] MEM_WB_NOP = 64'h0000_0000_0000_0000;

  function automatic logic [1:0] state_occ(input stage_state_e st);
    logic [1:0] occ;
    case (st)
      EMPTY:   occ = 2'd0;
      FULL:    occ = 2'd1;
      SKID:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer and
// synchronous flush that reloads a configurable bubble payload.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  stage_state_e      state_r;
  stage_state_e      state_s;
  logic [DATA_W-1:0] main_r;
  logic [DATA_W-1:0] main_s;
  logic [DATA_W-1:0] skid_r;
  logic [DATA_W-1:0] skid_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [1:0]        occ_r;
  logic              in_fire_s;
  logic              out_fire_s;

  assign in_fire_s  = in_valid_i & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready_i;

  // Next-state and storage update; flush overrides the handshake.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (flush_i) begin
      state_s = EMPTY;
      main_s  = FLUSH_VAL;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_s = FULL;
            main_s  = in_data_i;
          end else begin
            state_s = EMPTY;
          end
        end
        FULL: begin
          if (in_fire_s && out_fire_s) begin
            state_s = FULL;
            main_s  = in_data_i;
          end else if (in_fire_s) begin
            state_s = SKID;
            skid_s  = in_data_i;
          end else if (out_fire_s) begin
            state_s = EMPTY;
          end else begin
            state_s = FULL;
          end
        end
        SKID: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire_s) begin
            state_s = FULL;
            main_s  = skid_r;
          end else begin
            state_s = SKID;
          end
        end
        default: begin
          state_s = EMPTY;
          main_s  = FLUSH_VAL;
        end
      endcase
    end
  end

  // State, storage and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= EMPTY;
      main_r      <= FLUSH_VAL;
      skid_r      <= FLUSH_VAL;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occ_r       <= 2'd0;
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      in_ready_r  <= (state_s != SKID);
      out_valid_r <= (state_s != EMPTY);
      occ_r       <= state_occ(state_s);
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign out_data_o  = main_r;
  assign occ_o       = occ_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed handshake scenarios followed by
// randomized valid/ready/flush traffic, all compared against a queue-based model.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned     DW = 64;
  localparam logic [DW-1:0]   FV = IF_ID_NOP;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;

  int checks = 0;
  int errors = 0;

  // Model: the held payloads in delivery order, plus the last value shown on out_data.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last = FV;
  int            m_deliv = 0;
  int            d_deliv = 0;

  pipe_stage_skid #(.DATA_W(DW), .FLUSH_VAL(FV)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .occ_o      (occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [DW-1:0] d, input logic ordy);
    logic m_in_fire;
    logic m_out_fire;
    logic [DW-1:0] head;
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    m_in_fire  = iv && (mq.size() < 2);
    m_out_fire = ordy && (mq.size() > 0);
    head = (mq.size() > 0) ? mq[0] : m_last;
    if (!r && (out_valid === 1'b1) && ordy) begin
      d_deliv++;
      chk("deliver", out_data, head);
    end
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      m_last = FV;
    end else if (f) begin
      if (m_out_fire) m_deliv++;
      mq.delete();
      m_last = FV;
    end else begin
      if (m_out_fire) begin
        void'(mq.pop_front());
        m_deliv++;
      end
      if (m_in_fire) mq.push_back(d);
      if (mq.size() > 0) m_last = mq[0];
    end
    chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
    chk("in_ready",  {63'd0, in_ready},  {63'd0, mq.size() < 2});
    chk("occ",       {62'd0, occ},       64'(mq.size()));
    chk("out_data",  out_data,           m_last);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset held two cycles with a payload offered: nothing accepted.
    cyc(1'b1, 1'b0, 1'b1, 64'h55, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 64'h55, 1'b0);
    chk("reset_data_const", out_data, FV);

    // Back-to-back streaming, one-cycle latency.
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 1'b1, 64'(i), 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    chk("stream_last_hold", out_data, 64'h8);

    // Back-pressure fills the skid entry; 0xC must wait.
    cyc(1'b0, 1'b0, 1'b1, 64'hA, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 64'hB, 1'b0);
    chk("bp_occ2", {62'd0, occ}, 64'd2);
    cyc(1'b0, 1'b0, 1'b1, 64'hC, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 64'hC, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 64'hC, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

    // Flush while in SKID with 0xD offered: 0xD dropped.
    cyc(1'b0, 1'b0, 1'b1, 64'h11, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 64'h12, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 64'hD, 1'b0);
    chk("flush_skid_data", out_data, FV);
    cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

    // Flush coinciding with an out_fire: delivered exactly once.
    cyc(1'b0, 1'b0, 1'b1, 64'h21, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    chk("directed_deliv_count", 64'(d_deliv), 64'(m_deliv));
    chk("directed_deliv_total", 64'(m_deliv), 64'd12);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 63) == 0,
          $urandom_range(0, 3) != 0, {$urandom, $urandom},
          $urandom_range(0, 3) != 0);
    end
    chk("random_deliv_count", 64'(d_deliv), 64'(m_deliv));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
